// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and constants for the sequential divider
// Purpose: operation/state enums and width constants used by seq_divider,
//          its bus interface and the div_step iteration slice.
// Ports:   none (package).
package div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam logic [DIV_WIDTH-1:0] DIV_ALL_ONES = {DIV_WIDTH{1'b1}};

    // Encoding equals funct3[1:0]: bit 1 selects remainder, bit 0 selects unsigned.
    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } div_state_t;

endpackage

// File: rtl/seq_divider_if.sv
// rtl/seq_divider_if.sv - start/done handshake bundle between execute control and divider
// Purpose: groups the request (start/op/a/b) and response (busy/done/result) signals.
// Ports:   master drives start, op, a, b and observes busy, done, result;
//          slave (the divider) is the mirror image.
interface seq_divider_if #(
    parameter int WIDTH = div_pkg::DIV_WIDTH
);
    import div_pkg::*;

    logic             start;
    div_op_t          op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output start, op, a, b,
        input  busy, done, result
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result
    );

endinterface

// File: rtl/div_step.sv
// rtl/div_step.sv - one radix-2 restoring division iteration
// Purpose: shifts {rem,quo} left by one, trial-subtracts the divisor and
//          restores or keeps the partial remainder.
// Ports:   rem_i/quo_i/div_i current partial remainder, quotient, divisor;
//          rem_o/quo_o values after this iteration.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] div_i,
    output logic [WIDTH:0]   rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH+1:0] shifted_rem;
    logic [WIDTH+1:0] trial;
    logic             trial_ok;

    // One extra bit above the shifted remainder makes the borrow visible as a sign bit.
    assign shifted_rem = {rem_i, quo_i[WIDTH-1]};
    assign trial       = shifted_rem - {2'b00, div_i};
    assign trial_ok    = ~trial[WIDTH+1];

    assign rem_o = trial_ok ? trial[WIDTH:0] : shifted_rem[WIDTH:0];
    assign quo_o = {quo_i[WIDTH-2:0], trial_ok};

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multicycle RV32M DIV/DIVU/REM/REMU unit
// Purpose: restoring division, one quotient bit per clock; divide-by-zero and
//          signed overflow are resolved at start and finish in one cycle.
// Ports:   clk, rst (async, active-high); bus (seq_divider_if.slave):
//          start/op/a/b request, busy/done/result response.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic         clk,
    input  logic         rst,
    seq_divider_if.slave bus
);

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_t       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH:0]   rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] div_q;
    logic             neg_a_q;
    logic             neg_b_q;
    logic             op_rem_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] result_q;

    logic             is_signed_d;
    logic             neg_a_d;
    logic             neg_b_d;
    logic [WIDTH-1:0] abs_a_d;
    logic [WIDTH-1:0] abs_b_d;
    logic             div_zero_d;
    logic             overflow_d;
    logic [WIDTH-1:0] res_special_d;
    logic [WIDTH:0]   rem_d;
    logic [WIDTH-1:0] quo_d;
    logic [WIDTH-1:0] q_fix_d;
    logic [WIDTH-1:0] r_fix_d;
    logic [WIDTH-1:0] res_calc_d;

    assign is_signed_d = ~bus.op[0];
    assign neg_a_d     = is_signed_d & bus.a[WIDTH-1];
    assign neg_b_d     = is_signed_d & bus.b[WIDTH-1];
    // Negating MIN_NEG wraps back to itself, which is the correct unsigned magnitude.
    assign abs_a_d     = neg_a_d ? -bus.a : bus.a;
    assign abs_b_d     = neg_b_d ? -bus.b : bus.b;

    assign div_zero_d  = (bus.b == '0);
    assign overflow_d  = is_signed_d && (bus.a == MIN_NEG) && (bus.b == DIV_ALL_ONES);

    // Divide-by-zero wins over overflow.
    always_comb begin
        res_special_d = '0;
        if (div_zero_d) begin
            res_special_d = bus.op[1] ? bus.a : DIV_ALL_ONES;
        end else begin
            res_special_d = bus.op[1] ? '0 : MIN_NEG;
        end
    end

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .div_i (div_q),
        .rem_o (rem_d),
        .quo_o (quo_d)
    );

    // Fix-up is taken from the step outputs so the final iteration and the
    // result load happen in the same cycle.
    assign q_fix_d    = (neg_a_q ^ neg_b_q) ? -quo_d : quo_d;
    assign r_fix_d    = neg_a_q ? -rem_d[WIDTH-1:0] : rem_d[WIDTH-1:0];
    assign res_calc_d = op_rem_q ? r_fix_d : q_fix_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            div_q    <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            op_rem_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        busy_q   <= 1'b1;
                        op_rem_q <= bus.op[1];
                        neg_a_q  <= neg_a_d;
                        neg_b_q  <= neg_b_d;
                        quo_q    <= abs_a_d;
                        rem_q    <= '0;
                        div_q    <= abs_b_d;
                        cnt_q    <= CNT_W'(WIDTH - 1);
                        if (div_zero_d || overflow_d) begin
                            result_q <= res_special_d;
                            done_q   <= 1'b1;
                            state_q  <= DONE;
                        end else begin
                            state_q  <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        result_q <= res_calc_d;
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multicycle 32-bit integer divider for the RV32M execute stage. It is the division counterpart to the combinational multiplier.
- Implements DIV, DIVU, REM and REMU using radix-2 restoring division, one quotient bit per clock.
- Uses a start/done handshake toward the execute-stage control logic. Results are registered and held until the next accepted start.

Parameters:
- WIDTH, 32, operand/result width in bits (only 32 is verified).
- CNT_W, 5, iteration counter width, equal to $clog2(WIDTH).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  request pulse; sampled only in IDLE.
- op  in  2  div_op_t: DIV=00, DIVU=01, REM=10, REMU=11 (equals funct3[1:0]).
- a  in  WIDTH  dividend; captured when start is accepted.
- b  in  WIDTH  divisor; captured when start is accepted.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse; result is valid from this cycle onward.
- result  out  WIDTH  quotient (DIV/DIVU) or remainder (REM/REMU).

Behaviour:
- Reset (async, any state): state=IDLE, busy=0, done=0, result=0, internal regs=0. Reset mid-operation abandons the operation silently; no done pulse is produced.
- States:
  - IDLE: start=1 moves to CALC, or directly to DONE for a special case. start=0 stays in IDLE.
  - CALC: runs 32 iterations, counter from WIDTH-1 down to 0. When the counter reaches 0, go to DONE.
  - DONE: done=1 and result is loaded this cycle. Next state is IDLE unconditionally.
- start while busy=1 is ignored; inputs are not re-captured. a, b and op may change freely after acceptance.
- Capture on accepted start (cycle T):
  - signed ops: neg_a=a[31], neg_b=b[31], and operand magnitudes are taken as unsigned two's-complement absolute values; |0x80000000| = 0x80000000.
  - unsigned ops: neg flags are 0 and the raw values are used.
  - quo=|a|, rem=0 (WIDTH+1 bits), div=|b|.
- Iteration (each CALC cycle):
  - {rem,quo} is shifted left by 1.
  - trial = rem - {0,div}.
  - If trial is non-negative: rem=trial and quo[0]=1; otherwise quo[0]=0.
- Sign fix-up when entering DONE:
  - q = (neg_a ^ neg_b) ? -quo : quo.
  - r = neg_a ? -rem[WIDTH-1:0] : rem[WIDTH-1:0]; the remainder takes the dividend's sign.
  - result = op[1] ? r : q.
- Normal latency: start at T, CALC T+1..T+32, done=1 at T+33, IDLE at T+34. The earliest next accepted start is T+34.
- Special cases are resolved in IDLE and go straight to DONE, so done=1 at T+1:
  - b==0, any op: quotient = all ones (0xFFFFFFFF); remainder = a.
  - DIV/REM with a==0x80000000 and b==0xFFFFFFFF: quotient = 0x80000000; remainder = 0.
- Division by zero takes priority over overflow.
- result holds its value after DONE until the next DONE or reset; it never glitches during CALC.
- a=0 with nonzero b takes the normal 33-cycle path and yields 0/0. There is no early-out.

Decomposition:
- Package div_pkg holds:
  - typedef enum logic [1:0] div_op_t {DIV, DIVU, REM, REMU};
  - typedef enum logic [1:0] div_state_t {IDLE, CALC, DONE};
  - constants DIV_WIDTH=32 and DIV_ALL_ONES.
- Sub-module div_step: combinational single restoring iteration.
  - Inputs rem, quo, div.
  - Outputs next rem, next quo.
  - Instantiated once; the FSM, counter and sign logic stay in seq_divider.

Test Plan:
- DIVU a=100, b=7, start at T -> busy=1 during T+1..T+33, done=1 only at T+33, result=14. Repeat with REMU -> result=2.
- DIV a=0xFFFFFFF9 (-7), b=2 -> result=0xFFFFFFFD (-3). REM with the same operands -> 0xFFFFFFFF (-1). REM a=7, b=0xFFFFFFFE (-2) -> result=1.
- Divide by zero:
  - DIV a=5, b=0 -> done at T+1, result=0xFFFFFFFF.
  - REMU a=5, b=0 -> result=5.
  - DIVU a=0, b=0 -> 0xFFFFFFFF.
- Overflow:
  - DIV a=0x80000000, b=0xFFFFFFFF -> done at T+1, result=0x80000000.
  - REM with the same operands -> result=0.
  - DIVU with the same operands -> 33-cycle path, result=0.
- Start pulse with a=9, b=3 at T+5 during an active DIVU 100/7 -> ignored; done still at T+33 and result=14. Assert rst at T+10 -> busy=0, done=0 and result=0 immediately, with no done pulse. A new DIVU 9/3 afterwards -> result=3.
- Back-to-back ops: DIVU 0xFFFFFFFF/1 then, at the first IDLE cycle, REMU 0xFFFFFFFF/0x10 -> results 0xFFFFFFFF then 0xF. result holds between ops. Randomized signed/unsigned operands are compared against a reference model.
